// File: rtl/npu_sigmoid_if.sv
// Sample/result bundle between the NPU scheduler/MAC and the activation stage.
// The master drives the sample, function select and strobe; the slave returns the activation.
interface npu_sigmoid_if;
    logic [47:0] npu_sigmoid_din;
    logic [1:0]  npu_sched_sigmoid_function_sel;
    logic        npu_sched_sigmoid_input_en;
    logic [15:0] npu_sigmoid_dout;

    modport master (
        output npu_sigmoid_din,
        output npu_sched_sigmoid_function_sel,
        output npu_sched_sigmoid_input_en,
        input  npu_sigmoid_dout
    );

    modport slave (
        input  npu_sigmoid_din,
        input  npu_sched_sigmoid_function_sel,
        input  npu_sched_sigmoid_input_en,
        output npu_sigmoid_dout
    );
endinterface

// File: rtl/npu_sigmoid.sv
// Activation stage: Q40.8 accumulator -> Q8.8 sigmoid/linear/step/bipolar (bipolar only with NPU_SIGMOID_BIPOLAR_EN).
// Latency: two registers, result valid after the edge following capture; one sample per clock.
// Backpressure: none; the strobe qualifies captures and dout holds its value between samples.
module npu_sigmoid (
    input logic          CLK,
    input logic          npu_rst,
    npu_sigmoid_if.slave bus
);
    logic signed [47:0] din_q;
    logic [1:0]         sel_q;
    logic               vld_q;
    logic [47:0]        mag;
    logic [15:0]        m16;
    logic [15:0]        y16;
    logic [15:0]        sig16;
    logic [15:0]        act;

    always_ff @(posedge CLK or negedge npu_rst) begin
        if (!npu_rst) begin
            din_q <= '0;
            sel_q <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= bus.npu_sched_sigmoid_input_en;
            if (bus.npu_sched_sigmoid_input_en) begin
                din_q <= bus.npu_sigmoid_din;
                sel_q <= bus.npu_sched_sigmoid_function_sel;
            end
        end
    end

    always_comb begin
        // -2^47 negates to itself, which read unsigned is still >= 1280 and clamps
        mag = din_q[47] ? (~din_q + 48'd1) : din_q;
        m16 = (mag >= 48'd1280) ? 16'd1280 : {5'd0, mag[10:0]};

        if (m16 < 16'd256)
            y16 = (m16 >> 2) + 16'd128;
        else if (m16 < 16'd608)
            y16 = (m16 >> 3) + 16'd160;
        else if (m16 < 16'd1280)
            y16 = (m16 >> 5) + 16'd216;
        else
            y16 = 16'd256;

        sig16 = din_q[47] ? (16'd256 - y16) : y16;
        act   = sig16;

        case (sel_q)
            2'd1: begin
                if (din_q > 48'sd32767)
                    act = 16'h7FFF;
                else if (din_q < -48'sd32768)
                    act = 16'h8000;
                else
                    act = din_q[15:0];
            end
            2'd2: act = din_q[47] ? 16'h0000 : 16'h0100;
            2'd3: begin
`ifdef NPU_SIGMOID_BIPOLAR_EN
                act = {sig16[14:0], 1'b0} - 16'd256;
`else
                act = sig16;
`endif
            end
            default: act = sig16;
        endcase
    end

    always_ff @(posedge CLK or negedge npu_rst) begin
        if (!npu_rst)
            bus.npu_sigmoid_dout <= '0;
        else if (vld_q)
            bus.npu_sigmoid_dout <= act;
    end
endmodule

// File: tb/tb_npu_sigmoid.sv
// Randomized and directed bench for npu_sigmoid against an arithmetic reference model.
module tb_npu_sigmoid;
    logic CLK = 1'b0;
    logic npu_rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    npu_sigmoid_if bus ();

    npu_sigmoid dut (
        .CLK     (CLK),
        .npu_rst (npu_rst),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    // Model pipeline: pend_* is the sample captured last edge, exp_dout the visible result
    logic [15:0] exp_dout = '0;
    logic [15:0] pend_val = '0;
    bit          pend_vld = 1'b0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_act(input logic [47:0] d, input logic [1:0] s);
        longint v, m, y, sg, r;
        logic [63:0] rv;
        v = longint'($signed(d));
        m = (v < 0) ? -v : v;
        if (m > 1280) m = 1280;
        if (m < 256)       y = m / 4 + 128;
        else if (m < 608)  y = m / 8 + 160;
        else if (m < 1280) y = m / 32 + 216;
        else               y = 256;
        sg = (v < 0) ? 256 - y : y;
        case (s)
            2'd1:    r = (v > 32767) ? 32767 : ((v < -32768) ? -32768 : v);
            2'd2:    r = (v >= 0) ? 256 : 0;
`ifdef NPU_SIGMOID_BIPOLAR_EN
            2'd3:    r = 2 * sg - 256;
`else
            2'd3:    r = sg;
`endif
            default: r = sg;
        endcase
        rv = r;
        return rv[15:0];
    endfunction

    task automatic step(input bit en, input logic [47:0] d, input logic [1:0] s, input string tag);
        @(negedge CLK);
        bus.npu_sched_sigmoid_input_en     = en;
        bus.npu_sigmoid_din                = d;
        bus.npu_sched_sigmoid_function_sel = s;
        @(posedge CLK);
        #1;
        if (pend_vld) exp_dout = pend_val;
        pend_vld = en;
        if (en) pend_val = ref_act(d, s);
        chk(tag, bus.npu_sigmoid_dout, exp_dout);
    endtask

    // Drive one sample, then one idle cycle so its result is visible; check against a literal
    task automatic vec(input logic [47:0] d, input logic [1:0] s, input logic [15:0] want, input string tag);
        step(1'b1, d, s, tag);
        step(1'b0, 48'h0, 2'd0, tag);
        chk(tag, bus.npu_sigmoid_dout, want);
    endtask

    function automatic logic [47:0] rand_din();
        logic [47:0] d;
        case ($urandom_range(0, 3))
            0: d = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
            1: d = 48'h8000_0000_0000;
            default: begin
                d = 48'($urandom_range(0, 3000));
                if ($urandom_range(0, 1) == 1) d = -d;
            end
        endcase
        return d;
    endfunction

    initial begin
        bus.npu_sched_sigmoid_input_en     = 1'b0;
        bus.npu_sigmoid_din                = '0;
        bus.npu_sched_sigmoid_function_sel = '0;
        #1;
        chk("reset_dout", bus.npu_sigmoid_dout, 16'h0000);
        #20;
        npu_rst = 1'b1;

        vec(48'h0,            2'd0, 16'h0080, "sig_zero");
        vec(48'h260,          2'd0, 16'h00EB, "sig_pos");
        vec(48'hFFFFFFFFFDA0, 2'd0, 16'h0015, "sig_neg");
        vec(48'hF05,          2'd0, 16'h0100, "sig_sat_hi");
        vec(48'hFFFFFFFFF0FB, 2'd0, 16'h0000, "sig_sat_lo");
        vec(48'h000000FFC7A0, 2'd0, 16'h0100, "sig_big_hi");
        vec(48'hFFFFFF003860, 2'd0, 16'h0000, "sig_big_lo");
        vec(48'h8000_0000_0000, 2'd0, 16'h0000, "sig_minint");
        vec(48'hFF,           2'd1, 16'h00FF, "lin_ff");
        vec(48'hF0,           2'd1, 16'h00F0, "lin_f0");
        vec(48'h000000FFC7A0, 2'd1, 16'h7FFF, "lin_sat_hi");
        vec(48'hFFFFFF003860, 2'd1, 16'h8000, "lin_sat_lo");
        vec(48'h0,            2'd2, 16'h0100, "step_zero");
        vec(48'hFFFFFFFFFFFF, 2'd2, 16'h0000, "step_neg");
`ifdef NPU_SIGMOID_BIPOLAR_EN
        vec(48'h0,            2'd3, 16'h0000, "bip_zero");
        vec(48'h260,          2'd3, 16'h00D6, "bip_pos");
        vec(48'hF05,          2'd3, 16'h0100, "bip_sat");
`else
        vec(48'h0,            2'd3, 16'h0080, "sel3_unipolar");
`endif

        // Back-to-back burst of 9, then idle: dout must hold the last result
        for (int i = 0; i < 9; i++)
            step(1'b1, rand_din(), 2'($urandom_range(0, 3)), "burst");
        for (int i = 0; i < 5; i++)
            step(1'b0, rand_din(), 2'($urandom_range(0, 3)), "hold");

        // Random traffic, including sel/din changes with the strobe low
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 3) != 0, rand_din(), 2'($urandom_range(0, 3)), "rand");

        // Reset asserted mid-stream must clear dout without a clock edge
        step(1'b1, 48'h260, 2'd0, "pre_rst");
        step(1'b1, 48'hF05, 2'd1, "pre_rst");
        @(negedge CLK);
        #2;
        npu_rst = 1'b0;
        #1;
        chk("rst_async", bus.npu_sigmoid_dout, 16'h0000);
        exp_dout = '0;
        pend_vld = 1'b0;
        @(posedge CLK);
        #1;
        chk("rst_held", bus.npu_sigmoid_dout, 16'h0000);
        @(negedge CLK);
        npu_rst = 1'b1;
        bus.npu_sched_sigmoid_input_en = 1'b0;
        step(1'b0, 48'h0, 2'd0, "post_rst_idle");
        step(1'b1, 48'hFFFFFFFFFDA0, 2'd0, "post_rst");
        step(1'b0, 48'h0, 2'd0, "post_rst");
        chk("post_rst_first", bus.npu_sigmoid_dout, 16'h0015);
        for (int i = 0; i < 20; i++)
            step($urandom_range(0, 1) == 1, rand_din(), 2'($urandom_range(0, 3)), "post_rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/npu_sigmoid.md
# npu_sigmoid

Activation-function stage of the NPU datapath. Takes the 48-bit fixed-point accumulator result from the neuron MAC and produces a 16-bit Q8.8 activation value. The scheduler selects the function per sample. Fully pipelined: accepts one sample per clock with a fixed two-cycle latency.

## Interface
Parameters:
- none; all widths are fixed.

Ports:
- CLK  in  1  system clock; all registers update on the rising edge.
- npu_rst  in  1  reset; asynchronous and active-low.
- npu_sigmoid_din  in  48  accumulator value; two's complement, Q40.8 (8 fractional bits).
- npu_sched_sigmoid_function_sel  in  2  function select: 0 = sigmoid, 1 = linear, 2 = step, 3 = bipolar sigmoid.
- npu_sched_sigmoid_input_en  in  1  sample strobe; when high, din and sel are captured this cycle.
- npu_sigmoid_dout  out  16  activation result; Q8.8 two's complement, registered.

## Operation
- Stage 1 (input register):
  - When en=1, capture din and sel.
  - When en=0, the stage holds its contents.
- Stage 2 (output register) computes from stage 1 as follows.
- Magnitude: m = |din|, computed on the full 48 bits.
  - Clamp m to 1280 (5.0) if m ≥ 1280. This includes the case din = -2^47.
- Piecewise-linear sigmoid y(m), Q8.8. Right shifts truncate.
  - m < 256: y = (m>>2) + 128
  - 256 ≤ m < 608: y = (m>>3) + 160
  - 608 ≤ m < 1280: y = (m>>5) + 216
  - m ≥ 1280: y = 256
- sel 0 (sigmoid): dout = y if din ≥ 0, else 256 − y. Range 0x0000..0x0100.
- sel 1 (linear): dout = din saturated to signed 16 bits.
  - Values above 0x7FFF give 0x7FFF.
  - Values below −0x8000 give 0x8000.
- sel 2 (step): dout = 0x0100 if din[47]=0 (zero included), else 0x0000.
- sel 3 (bipolar): s = sigmoid result from sel 0; dout = 2·s − 256. Signed Q8.8, range 0xFF00..0x0100.
- Stage 2 updates only in the cycle after stage 1 captured a sample. Otherwise dout holds its value.

## Timing
- Reset (npu_rst=0, asynchronous): stage-1 registers, the internal valid bit and dout all clear to 0.
- Latency: en sampled high at rising edge N → dout valid after rising edge N+1.
- Throughput: one sample per cycle. en may stay high continuously; each cycle's sample appears two edges later, in order.
- en low: no new capture and no dout update after the pipeline drains. dout holds the last result indefinitely.
- Reset mid-operation: in-flight samples are discarded and dout reads 0x0000 until a new sample propagates.
- The sel change is registered together with din. A sel change without en has no effect.

## Configuration
- Macro: NPU_SIGMOID_BIPOLAR_EN.
- Defined: sel 3 produces the bipolar sigmoid as specified.
- Undefined: the bipolar logic is not built, and sel 3 behaves identically to sel 0 (unipolar sigmoid).

## Test plan
- Reset, then en=1, sel=0:
  - din=0 → dout=0x0080
  - din=0x260 → 0x00EB
  - din=0xFFFFFFFFFDA0 → 0x0015
  - each result appears two edges after capture.
- sel=0 saturation:
  - din=0xF05 → 0x0100
  - din=0xFFFFFFFFF0FB → 0x0000
  - din=0x000000FFC7A0 → 0x0100
  - din=0xFFFFFF003860 → 0x0000
- sel=1 linear:
  - din=0xFF → 0x00FF
  - din=0xF0 → 0x00F0
  - din=0x000000FFC7A0 → 0x7FFF
  - din=0xFFFFFF003860 → 0x8000
- sel=2 step: din=0 → 0x0100; din=−1 → 0x0000. sel=3: din=0 → 0x0000; din=0x260 → 0x00D6; din=0xF05 → 0x0100. With the macro undefined, sel=3 with din=0 → 0x0080.
- Back-to-back: en held high over 9 consecutive samples → 9 results in order, one per cycle. en then dropped → dout holds the last value.
- Reset asserted mid-stream → dout clears to 0x0000 immediately, not waiting for a clock edge. After release, the first output equals the first post-reset sample, with no stale data.
